// File: rtl/instr_fetch_if.sv
// Register-id type plus the memory read bus and register-file write port of instr_fetch.
// The fetch sequencer drives the master modport; memory and register file sit on the slave side.
package instr_fetch_pkg;
    typedef enum logic [0:0] {
        R_IR1 = 1'b0,
        R_IR2 = 1'b1
    } reg_id_e;
endpackage

interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;
    logic        o_wr_en;
    reg_id_e     o_dest_addr;
    logic [15:0] o_dest_data;

    modport master (
        output o_mem_req,
        output o_mem_addr,
        input  i_mem_ack,
        input  i_mem_rdata,
        output o_wr_en,
        output o_dest_addr,
        output o_dest_data
    );

    modport slave (
        input  o_mem_req,
        input  o_mem_addr,
        output i_mem_ack,
        output i_mem_rdata,
        input  o_wr_en,
        input  o_dest_addr,
        input  o_dest_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, fetches one or two words and writes them to IR1/IR2.
// Optional INSTR_FETCH_CLR_IR2_EN: single-word instructions also write IR2 with zero.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          EXT_BIT  = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_jump_en,
    input  logic [15:0]        i_jump_addr,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_pc,
    instr_fetch_if.master      bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_WRITE1 = 3'd2,
        ST_FETCH2 = 3'd3,
        ST_WRITE2 = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    state_e      state_r;
    state_e      state_nx_s;
    logic [15:0] pc_r;
    logic [15:0] word_r;
    logic        jmp_pend_r;
    logic [15:0] jmp_addr_r;

    logic        busy_s;
    logic        done_s;
    logic        req_s;
    logic        wr_en_s;
    reg_id_e     dest_s;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and state-decoded outputs; ack is only honoured while requesting
    always_comb begin
        state_nx_s = state_r;
        busy_s     = 1'b1;
        done_s     = 1'b0;
        req_s      = 1'b0;
        wr_en_s    = 1'b0;
        dest_s     = R_IR1;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (i_start) begin
                    state_nx_s = ST_FETCH1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH1: begin
                req_s = 1'b1;
                if (bus.i_mem_ack) begin
                    state_nx_s = ST_WRITE1;
                end else begin
                    state_nx_s = ST_FETCH1;
                end
            end
            ST_WRITE1: begin
                wr_en_s = 1'b1;
                if (word_r[EXT_BIT]) begin
                    state_nx_s = ST_FETCH2;
                end else begin
`ifdef INSTR_FETCH_CLR_IR2_EN
                    state_nx_s = ST_WRITE2;
`else
                    state_nx_s = ST_DONE;
`endif
                end
            end
            ST_FETCH2: begin
                req_s = 1'b1;
                if (bus.i_mem_ack) begin
                    state_nx_s = ST_WRITE2;
                end else begin
                    state_nx_s = ST_FETCH2;
                end
            end
            ST_WRITE2: begin
                wr_en_s    = 1'b1;
                dest_s     = R_IR2;
                state_nx_s = ST_DONE;
            end
            ST_DONE: begin
                done_s     = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // PC, captured word and pending-jump bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_r       <= RESET_PC;
            word_r     <= 16'h0000;
            jmp_pend_r <= 1'b0;
            jmp_addr_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_jump_en) begin
                        pc_r <= i_jump_addr;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_FETCH1, ST_FETCH2: begin
                    if (bus.i_mem_ack) begin
                        word_r <= bus.i_mem_rdata;
                        pc_r   <= pc_r + 16'd1;
                    end else begin
                        word_r <= word_r;
                    end
                end
                ST_WRITE1: begin
`ifdef INSTR_FETCH_CLR_IR2_EN
                    // The IR2 clear write reuses the captured-word path with a zero word
                    if (!word_r[EXT_BIT]) begin
                        word_r <= 16'h0000;
                    end else begin
                        word_r <= word_r;
                    end
`else
                    word_r <= word_r;
`endif
                end
                ST_DONE: begin
                    // A jump arriving in DONE is the newest target and wins over the pending one
                    if (i_jump_en) begin
                        pc_r <= i_jump_addr;
                    end else if (jmp_pend_r) begin
                        pc_r <= jmp_addr_r;
                    end else begin
                        pc_r <= pc_r;
                    end
                    jmp_pend_r <= 1'b0;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase

            if ((state_r != ST_IDLE) && (state_r != ST_DONE) && i_jump_en) begin
                jmp_pend_r <= 1'b1;
                jmp_addr_r <= i_jump_addr;
            end
        end
    end

    assign o_busy          = busy_s;
    assign o_done          = done_s;
    assign o_pc            = pc_r;
    assign bus.o_mem_req   = req_s;
    assign bus.o_mem_addr  = pc_r;
    assign bus.o_wr_en     = wr_en_s;
    assign bus.o_dest_addr = dest_s;
    assign bus.o_dest_data = word_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected bus events are queued per scenario and matched
// against events recorded from the DUT with cycle offsets relative to the start pulse.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [1:0] K_REQ  = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] d;
        logic [7:0]  cyc;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        busy;
    logic        done;
    logic [15:0] pc;
    logic        resp_ack;
    logic [15:0] resp_rdata;
    logic        stray_ack;

    logic [15:0] mem [0:65535];
    int          wait_cfg;
    int          wcnt;
    int          cyc;
    int          t0;
    logic        prev_req;
    int          tests;
    int          fails;
    ev_t         exp_q[$];
    ev_t         obs_q[$];

    instr_fetch_if bus ();

    assign bus.i_mem_ack   = resp_ack | stray_ack;
    assign bus.i_mem_rdata = resp_rdata;

    instr_fetch dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_jump_en   (jump_en),
        .i_jump_addr (jump_addr),
        .o_busy      (busy),
        .o_done      (done),
        .o_pc        (pc),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic ev_t mk(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d, input int c);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        e.cyc  = 8'(c);
        return e;
    endfunction

    // Memory model: acks after wait_cfg request cycles
    initial begin
        resp_ack   = 1'b0;
        resp_rdata = 16'h0000;
        wcnt       = 0;
        forever begin
            @(negedge clk);
            if (bus.o_mem_req) begin
                if (wcnt >= wait_cfg) begin
                    resp_ack   = 1'b1;
                    resp_rdata = mem[bus.o_mem_addr];
                    wcnt       = 0;
                end else begin
                    resp_ack = 1'b0;
                    wcnt     = wcnt + 1;
                end
            end else begin
                resp_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // Event recorder: request starts, register writes and done pulses
    initial begin
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_mem_req && !prev_req)
                obs_q.push_back(mk(K_REQ, bus.o_mem_addr, 16'h0000, cyc - t0));
            prev_req = bus.o_mem_req;
            if (bus.o_wr_en)
                obs_q.push_back(mk(K_WR, 16'(bus.o_dest_addr), bus.o_dest_data, cyc - t0));
            if (done)
                obs_q.push_back(mk(K_DONE, 16'h0000, 16'h0000, cyc - t0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_pc(input logic [15:0] a);
        @(negedge clk);
        jump_en   = 1'b1;
        jump_addr = a;
        @(negedge clk);
        jump_en   = 1'b0;
        jump_addr = 16'h0000;
    endtask

    // Cycle k of the run is the cycle whose negedge drives the k-th stimulus; k=0 carries start
    task automatic run(input logic do_start, input logic jn, input logic [15:0] ja,
                       input int j1_at, input logic [15:0] j1_addr,
                       input int j2_at, input logic [15:0] j2_addr,
                       input int rst_at, input int ack_at, input int ncyc);
        @(negedge clk);
        t0 = cyc;
        obs_q.delete();
        for (int k = 0; k < ncyc; k++) begin
            start     = do_start && (k == 0);
            jump_en   = 1'b0;
            jump_addr = 16'h0000;
            if (k == 0 && jn) begin
                jump_en   = 1'b1;
                jump_addr = ja;
            end else if (k == j1_at) begin
                jump_en   = 1'b1;
                jump_addr = j1_addr;
            end else if (k == j2_at) begin
                jump_en   = 1'b1;
                jump_addr = j2_addr;
            end
            rst       = (k == rst_at);
            stray_ack = (k == ack_at) || (k == ack_at + 1);
            @(negedge clk);
        end
        start     = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 16'h0000;
        rst       = 1'b0;
        stray_ack = 1'b0;
    endtask

    task automatic exp_single(input logic [15:0] addr, input logic [15:0] word, input int w);
        exp_q.push_back(mk(K_REQ, addr, 16'h0000, 1));
        exp_q.push_back(mk(K_WR, 16'(R_IR1), word, 2 + w));
`ifdef INSTR_FETCH_CLR_IR2_EN
        exp_q.push_back(mk(K_WR, 16'(R_IR2), 16'h0000, 3 + w));
        exp_q.push_back(mk(K_DONE, 16'h0000, 16'h0000, 4 + w));
`else
        exp_q.push_back(mk(K_DONE, 16'h0000, 16'h0000, 3 + w));
`endif
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests += 8;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want 0000", pc); end
        if (bus.o_mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.o_mem_req); end
        if (bus.o_mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", bus.o_mem_addr); end
        if (bus.o_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", bus.o_wr_en); end
        if (bus.o_dest_addr !== R_IR1) begin fails++; $display("FAIL reset_dest: got %0d want R_IR1", bus.o_dest_addr); end
        if (bus.o_dest_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", bus.o_dest_data); end
    endtask

    task automatic test_single();
        ev_t e;
        ev_t o;
        mem[16'h0000] = 16'h1234;
        wait_cfg = 0;
        exp_single(16'h0000, 16'h1234, 0);
        run(1'b1, 1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, -10, 8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL single_ev: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL single_ev: got %h want %h", o, e); end
            end
        end
        tests += 2;
        if (obs_q.size() != 0) begin fails++; $display("FAIL single_extra: got %0d events want 0", obs_q.size()); end
        if (pc !== 16'h0001) begin fails++; $display("FAIL single_pc: got %h want 0001", pc); end
    endtask

    task automatic test_two_word();
        ev_t e;
        ev_t o;
        mem[16'h0010] = 16'h8001;
        mem[16'h0011] = 16'hBEEF;
        wait_cfg = 2;
        set_pc(16'h0010);
        exp_q.push_back(mk(K_REQ, 16'h0010, 16'h0000, 1));
        exp_q.push_back(mk(K_WR, 16'(R_IR1), 16'h8001, 4));
        exp_q.push_back(mk(K_REQ, 16'h0011, 16'h0000, 5));
        exp_q.push_back(mk(K_WR, 16'(R_IR2), 16'hBEEF, 8));
        exp_q.push_back(mk(K_DONE, 16'h0000, 16'h0000, 9));
        run(1'b1, 1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, -10, 13);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL two_word_ev: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL two_word_ev: got %h want %h", o, e); end
            end
        end
        tests += 2;
        if (obs_q.size() != 0) begin fails++; $display("FAIL two_word_extra: got %0d events want 0", obs_q.size()); end
        if (pc !== 16'h0012) begin fails++; $display("FAIL two_word_pc: got %h want 0012", pc); end
        wait_cfg = 0;
    endtask

    task automatic test_jump_start();
        ev_t e;
        ev_t o;
        mem[16'h4000] = 16'h00AB;
        exp_single(16'h4000, 16'h00AB, 0);
        run(1'b1, 1'b1, 16'h4000, -1, 16'h0, -1, 16'h0, -1, -10, 8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL jump_start_ev: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL jump_start_ev: got %h want %h", o, e); end
            end
        end
        tests += 2;
        if (obs_q.size() != 0) begin fails++; $display("FAIL jump_start_extra: got %0d events want 0", obs_q.size()); end
        if (pc !== 16'h4001) begin fails++; $display("FAIL jump_start_pc: got %h want 4001", pc); end
    endtask

    task automatic test_jump_pending();
        ev_t e;
        ev_t o;
        mem[16'h0005] = 16'h0777;
        wait_cfg = 3;
        set_pc(16'h0005);
        exp_single(16'h0005, 16'h0777, 3);
        // Second jump overwrites the first pending target
        run(1'b1, 1'b0, 16'h0, 2, 16'h1111, 3, 16'h2000, -1, -10, 11);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL jump_pend_ev: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL jump_pend_ev: got %h want %h", o, e); end
            end
        end
        tests += 2;
        if (obs_q.size() != 0) begin fails++; $display("FAIL jump_pend_extra: got %0d events want 0", obs_q.size()); end
        if (pc !== 16'h2000) begin fails++; $display("FAIL jump_pend_pc: got %h want 2000", pc); end
        wait_cfg = 0;
    endtask

    task automatic test_jump_in_done();
        int done_c;
        mem[16'h0200] = 16'h0042;
        set_pc(16'h0200);
`ifdef INSTR_FETCH_CLR_IR2_EN
        done_c = 4;
`else
        done_c = 3;
`endif
        run(1'b1, 1'b0, 16'h0, done_c, 16'h3333, -1, 16'h0, -1, -10, 8);
        tests += 1;
        if (pc !== 16'h3333) begin fails++; $display("FAIL jump_done_pc: got %h want 3333", pc); end
    endtask

    task automatic test_wrap();
        ev_t e;
        ev_t o;
        mem[16'hFFFF] = 16'h0001;
        set_pc(16'hFFFF);
        exp_single(16'hFFFF, 16'h0001, 0);
        run(1'b1, 1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, -10, 8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL wrap_ev: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL wrap_ev: got %h want %h", o, e); end
            end
        end
        tests += 2;
        if (obs_q.size() != 0) begin fails++; $display("FAIL wrap_extra: got %0d events want 0", obs_q.size()); end
        if (pc !== 16'h0000) begin fails++; $display("FAIL wrap_pc: got %h want 0000", pc); end
    endtask

    task automatic test_reset_mid();
        ev_t e;
        ev_t o;
        mem[16'h0020] = 16'h8123;
        mem[16'h0021] = 16'h4567;
        wait_cfg = 10;
        set_pc(16'h0020);
        exp_q.push_back(mk(K_REQ, 16'h0020, 16'h0000, 1));
        exp_q.push_back(mk(K_WR, 16'(R_IR1), 16'h8123, 12));
        exp_q.push_back(mk(K_REQ, 16'h0021, 16'h0000, 13));
        // Reset in the FETCH2 wait at cycle 15, stray ack over cycles 15 and 16
        run(1'b1, 1'b0, 16'h0, -1, 16'h0, -1, 16'h0, 15, 15, 22);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL rst_mid_ev: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL rst_mid_ev: got %h want %h", o, e); end
            end
        end
        tests += 4;
        if (obs_q.size() != 0) begin fails++; $display("FAIL rst_mid_extra: got %0d events want 0", obs_q.size()); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        if (pc !== 16'h0000) begin fails++; $display("FAIL rst_mid_pc: got %h want 0000", pc); end
        if (bus.o_mem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_req: got %b want 0", bus.o_mem_req); end
        wait_cfg = 0;
    endtask

    task automatic test_after_reset();
        ev_t e;
        ev_t o;
        mem[16'h0000] = 16'h0C0D;
        exp_single(16'h0000, 16'h0C0D, 0);
        run(1'b1, 1'b0, 16'h0, -1, 16'h0, -1, 16'h0, -1, -10, 8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL after_rst_ev: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL after_rst_ev: got %h want %h", o, e); end
            end
        end
        tests += 2;
        if (obs_q.size() != 0) begin fails++; $display("FAIL after_rst_extra: got %0d events want 0", obs_q.size()); end
        if (pc !== 16'h0001) begin fails++; $display("FAIL after_rst_pc: got %h want 0001", pc); end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 16'h0000;
        stray_ack = 1'b0;
        wait_cfg  = 0;
        t0        = 0;
        tests     = 0;
        fails     = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_two_word();
        test_jump_start();
        test_jump_pending();
        test_jump_in_done();
        test_wrap();
        test_reset_mid();
        test_after_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
